// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack CPU: push/pop/tos strobes in, registered top-of-stack out.
// The error flags are sticky. A cycle that raises an error leaves count, storage and dout untouched.
module stack_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic              illegal
);

    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ill_q, ill_d;

    logic              is_empty, is_full;
    logic              wr_en;
    logic              set_ovf, set_unf, set_ill;
    logic [PTR_W-1:0]  wr_idx, top_idx;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    // Low PTR_W bits suffice: writes only happen below DEPTH, and at count==DEPTH
    // the low bits are zero so top_idx wraps to DEPTH-1 as required.
    assign wr_idx  = count_q[PTR_W-1:0];
    assign top_idx = count_q[PTR_W-1:0] - IDX_ONE;

    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        wr_en   = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        set_ill = 1'b0;
        if (push && pop) begin
            set_ill = 1'b1;
        end else if (push) begin
            if (!is_full) begin
                wr_en   = 1'b1;
                count_d = count_q + CNT_ONE;
                dout_d  = din;
            end else begin
                set_ovf = 1'b1;
            end
        end else if (pop) begin
            if (!is_empty) begin
                dout_d  = mem_q[top_idx];
                count_d = count_q - CNT_ONE;
            end else begin
                set_unf = 1'b1;
            end
        end else if (tos) begin
            if (!is_empty) begin
                dout_d = mem_q[top_idx];
            end else begin
                set_unf = 1'b1;
            end
        end
        // A new error in the same cycle as clr_err keeps the flag set.
        ovf_d = (ovf_q & ~clr_err) | set_ovf;
        unf_d = (unf_q & ~clr_err) | set_unf;
        ill_d = (ill_q & ~clr_err) | set_ill;
    end

    // Storage has no reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            ill_q   <= ill_d;
        end
    end

    assign dout      = dout_q;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed scenario followed by random traffic, checked against a queue model.
module tb_stack_unit;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = 4;

    logic              clk;
    logic              rst;
    logic              push, pop, tos, clr_err;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic [PTR_W:0]    count;
    logic              empty, full, overflow, underflow, illegal;

    int n_assert;
    int n_fail;

    // reference model state
    logic [DATA_W-1:0] stk[$];
    logic [DATA_W-1:0] m_dout;
    logic              m_ovf, m_unf, m_ill;

    stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .clr_err(clr_err),
        .din(din), .dout(dout), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow), .illegal(illegal)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_ill  = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic q, input logic t,
                              input logic c, input logic [DATA_W-1:0] d);
        logic so, su, si;
        so = 1'b0; su = 1'b0; si = 1'b0;
        if (p && q) si = 1'b1;
        else if (p) begin
            if (stk.size() < DEPTH) begin stk.push_back(d); m_dout = d; end
            else so = 1'b1;
        end else if (q) begin
            if (stk.size() > 0) m_dout = stk.pop_back();
            else su = 1'b1;
        end else if (t) begin
            if (stk.size() > 0) m_dout = stk[stk.size()-1];
            else su = 1'b1;
        end
        m_ovf = (m_ovf && !c) || so;
        m_unf = (m_unf && !c) || su;
        m_ill = (m_ill && !c) || si;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},     32'(count),     32'(stk.size()));
        chk({tag, ".empty"},     32'(empty),     32'(stk.size() == 0));
        chk({tag, ".full"},      32'(full),      32'(stk.size() == DEPTH));
        chk({tag, ".dout"},      32'(dout),      32'(m_dout));
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
        chk({tag, ".illegal"},   32'(illegal),   32'(m_ill));
    endtask

    // driver: inputs applied 1 time unit after an edge, sampled on the next edge
    task automatic step(input string tag, input logic p, input logic q, input logic t,
                        input logic c, input logic [DATA_W-1:0] d);
        push = p; pop = q; tos = t; clr_err = c; din = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0;
        model_step(p, q, t, c, d);
        check_all(tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0; din = '0;
        model_reset();
        #1;
        chk("reset.count", 32'(count), 32'd0);
        chk("reset.dout",  32'(dout),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset");

        // fill three, peek, drain, then underflow
        step("push11", 1, 0, 0, 0, 8'h11);
        step("push22", 1, 0, 0, 0, 8'h22);
        step("push33", 1, 0, 0, 0, 8'h33);
        chk("push3.count", 32'(count), 32'd3);
        step("tos", 0, 0, 1, 0, 8'h00);
        chk("tos.dout", 32'(dout), 32'h33);
        chk("tos.count", 32'(count), 32'd3);
        step("pop1", 0, 1, 0, 0, 8'h00);
        chk("pop1.dout", 32'(dout), 32'h33);
        step("pop2", 0, 1, 0, 0, 8'h00);
        chk("pop2.dout", 32'(dout), 32'h22);
        step("pop3", 0, 1, 0, 0, 8'h00);
        chk("pop3.dout", 32'(dout), 32'h11);
        chk("pop3.empty", 32'(empty), 32'd1);
        step("pop4", 0, 1, 0, 0, 8'h00);
        chk("pop4.underflow", 32'(underflow), 32'd1);
        chk("pop4.dout", 32'(dout), 32'h11);
        chk("pop4.count", 32'(count), 32'd0);

        // fill to DEPTH, overflow, pop
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0, 0, 8'(i));
        chk("fill.full", 32'(full), 32'd1);
        step("push_full", 1, 0, 0, 0, 8'hAA);
        chk("ovf.overflow", 32'(overflow), 32'd1);
        chk("ovf.count", 32'(count), 32'd16);
        step("pop_after_ovf", 0, 1, 0, 0, 8'h00);
        chk("pop_after_ovf.dout", 32'(dout), 32'h0F);

        // down to 2 entries, then push&pop together
        for (int i = 0; i < DEPTH - 3; i++) step("drain", 0, 1, 0, 0, 8'h00);
        chk("drain.count", 32'(count), 32'd2);
        step("push_pop", 1, 1, 1, 0, 8'h77);
        chk("push_pop.illegal", 32'(illegal), 32'd1);
        chk("push_pop.count", 32'(count), 32'd2);
        chk("push_pop.dout", 32'(dout), 32'h02);
        step("clr", 0, 0, 0, 1, 8'h00);
        chk("clr.flags", 32'({overflow, underflow, illegal}), 32'd0);

        // set-wins: clear while a new underflow-free error occurs
        step("clr_vs_ill", 1, 1, 0, 1, 8'h00);
        chk("clr_vs_ill.illegal", 32'(illegal), 32'd1);
        step("clr2", 0, 0, 0, 1, 8'h00);

        // async reset between edges at count=5
        for (int i = 0; i < 3; i++) step("to5", 1, 0, 0, 0, 8'(8'hC0 + i));
        chk("to5.count", 32'(count), 32'd5);
        #3;
        rst = 1'b1;
        #1;
        chk("async.count", 32'(count), 32'd0);
        chk("async.dout",  32'(dout),  32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("after_rst");
        step("push5a", 1, 0, 0, 0, 8'h5A);
        step("pop5a", 0, 1, 0, 0, 8'h00);
        chk("pop5a.dout", 32'(dout), 32'h5A);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            logic p, q, t, c;
            r = $urandom_range(0, 99);
            p = 0; q = 0; t = 0;
            if (r < 40) p = 1;
            else if (r < 75) q = 1;
            else if (r < 90) t = 1;
            else if (r < 94) begin p = 1; q = 1; end
            c = ($urandom_range(0, 15) == 0);
            step("rand", p, q, t, c, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
